// File: rtl/wb_stage.sv
// Write-back stage register: captures the memory-stage slot, decodes the destination
// register, extracts load bytes and drives the register-file write port.
module wb_stage #(
   parameter int          CNT_W    = 32,
   parameter logic [31:0] LINK_OFS = 32'd8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      mem_inst,
   input  logic [31:0]      mem_pc,
   input  logic [31:0]      mem_alu_out,
   input  logic [31:0]      load_data,
   input  logic             mem_valid,
   input  logic             wb_en,
   input  logic             wb_flush,
   output logic [31:0]      wb_inst,
   output logic [31:0]      wb_pc,
   output logic             wb_valid,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [CNT_W-1:0] retire_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0] alu_q;
   logic [31:0] load_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_inst      <= '0;
         wb_pc        <= '0;
         alu_q        <= '0;
         load_q       <= '0;
         wb_valid     <= 1'b0;
         retire_count <= '0;
      end else if (wb_flush) begin
         // only the slot identity is squashed; data registers simply hold
         wb_inst  <= '0;
         wb_valid <= 1'b0;
      end else if (wb_en) begin
         wb_inst  <= mem_inst;
         wb_pc    <= mem_pc;
         alu_q    <= mem_alu_out;
         load_q   <= load_data;
         wb_valid <= mem_valid;
         if (mem_valid)
            retire_count <= retire_count + CNT_ONE;
      end
   end

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [1:0]  ofs;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        writes;
   logic [4:0]  dest;
   logic [31:0] data;

   assign op    = wb_inst[31:26];
   assign rt    = wb_inst[20:16];
   assign rd    = wb_inst[15:11];
   assign funct = wb_inst[5:0];
   assign ofs   = alu_q[1:0];

   always_comb begin
      ld_byte = load_q[7:0];
      case (ofs)
         2'd0: ld_byte = load_q[7:0];
         2'd1: ld_byte = load_q[15:8];
         2'd2: ld_byte = load_q[23:16];
         2'd3: ld_byte = load_q[31:24];
         default: ld_byte = load_q[7:0];
      endcase
      ld_half = ofs[1] ? load_q[31:16] : load_q[15:0];
   end

   always_comb begin
      writes = 1'b0;
      dest   = rd;
      data   = alu_q;
      if (op == 6'h00) begin
         // jr, syscall and the hi/lo arithmetic group never touch the GPRs
         writes = !((funct == 6'h08) || (funct == 6'h0C) || (funct[5:2] == 4'b0110));
      end else if (op[5:3] == 3'b001) begin
         writes = 1'b1;
         dest   = rt;
      end else begin
         case (op)
            6'h20: begin writes = 1'b1; dest = rt; data = {{24{ld_byte[7]}}, ld_byte}; end
            6'h21: begin writes = 1'b1; dest = rt; data = {{16{ld_half[15]}}, ld_half}; end
            6'h23: begin writes = 1'b1; dest = rt; data = load_q; end
            6'h24: begin writes = 1'b1; dest = rt; data = {24'h0, ld_byte}; end
            6'h25: begin writes = 1'b1; dest = rt; data = {16'h0, ld_half}; end
            6'h03: begin writes = 1'b1; dest = 5'd31; data = wb_pc + LINK_OFS; end
            default: writes = 1'b0;
         endcase
      end
   end

   assign rf_we    = wb_valid & writes & (dest != 5'd0);
   assign rf_waddr = dest;
   assign rf_wdata = data;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: each step pushes its expected write-port state to a
// scoreboard, which is popped and compared just after the capturing edge.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_inst = '0, mem_pc = '0, mem_alu_out = '0, load_data = '0;
   logic        mem_valid = 1'b0, wb_en = 1'b0, wb_flush = 1'b0;

   logic [31:0] wb_inst, wb_pc, rf_wdata, retire_count;
   logic        wb_valid, rf_we;
   logic [4:0]  rf_waddr;

   logic [31:0] wb_inst4, wb_pc4, rf_wdata4;
   logic        wb_valid4, rf_we4;
   logic [4:0]  rf_waddr4;
   logic [3:0]  retire_count4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic        chk_ad;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        valid;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n), .mem_inst(mem_inst), .mem_pc(mem_pc),
      .mem_alu_out(mem_alu_out), .load_data(load_data), .mem_valid(mem_valid),
      .wb_en(wb_en), .wb_flush(wb_flush), .wb_inst(wb_inst), .wb_pc(wb_pc),
      .wb_valid(wb_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .retire_count(retire_count)
   );

   wb_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .mem_inst(mem_inst), .mem_pc(mem_pc),
      .mem_alu_out(mem_alu_out), .load_data(load_data), .mem_valid(mem_valid),
      .wb_en(wb_en), .wb_flush(wb_flush), .wb_inst(wb_inst4), .wb_pc(wb_pc4),
      .wb_valid(wb_valid4), .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
      .retire_count(retire_count4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] ld, input logic v, input logic en, input logic fl,
                       input logic we, input logic chk_ad, input logic [4:0] addr,
                       input logic [31:0] data, input logic valid, input logic [31:0] cnt,
                       input string tag);
      exp_t e;
      @(negedge clk);
      mem_inst = inst; mem_pc = pc; mem_alu_out = alu; load_data = ld;
      mem_valid = v; wb_en = en; wb_flush = fl;
      e.we = we; e.chk_ad = chk_ad; e.addr = addr; e.data = data; e.valid = valid; e.cnt = cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, " sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, e.we});
         check({tag, " wb_valid"}, {31'd0, wb_valid}, {31'd0, e.valid});
         check({tag, " count"}, retire_count, e.cnt);
         if (e.chk_ad) begin
            check({tag, " waddr"}, {27'd0, rf_waddr}, {27'd0, e.addr});
            check({tag, " wdata"}, rf_wdata, e.data);
         end
      end
   endtask

   localparam logic [31:0] LD = 32'h80FF7F01;
   localparam logic [31:0] ADD8 = 32'h012A4020;
   localparam logic [31:0] ADD11 = 32'h012A5820;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst rf_we", {31'd0, rf_we}, 32'd0);
      check("rst rf_waddr", {27'd0, rf_waddr}, 32'd0);
      check("rst rf_wdata", rf_wdata, 32'd0);
      check("rst wb_inst", wb_inst, 32'd0);
      check("rst wb_pc", wb_pc, 32'd0);
      check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst count", retire_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //    inst          pc            alu           ld  v  en fl  we ad addr  data          vld cnt
      step(ADD8,        32'h100,      32'h7,        LD, 1, 1, 0,  1, 1, 5'd8, 32'h7,        1, 1, "add");
      step(32'h80050000, 32'h104,     32'h3,        LD, 1, 1, 0,  1, 1, 5'd5, 32'hFFFFFF80, 1, 2, "lb3");
      step(32'h90060000, 32'h108,     32'h2,        LD, 1, 1, 0,  1, 1, 5'd6, 32'h000000FF, 1, 3, "lbu2");
      step(32'h84070000, 32'h10C,     32'h2,        LD, 1, 1, 0,  1, 1, 5'd7, 32'hFFFF80FF, 1, 4, "lh2");
      step(32'h94080000, 32'h110,     32'h0,        LD, 1, 1, 0,  1, 1, 5'd8, 32'h00007F01, 1, 5, "lhu0");
      step(32'h8C090000, 32'h114,     32'h1,        LD, 1, 1, 0,  1, 1, 5'd9, 32'h80FF7F01, 1, 6, "lw");
      step(32'h0C000010, 32'h00400010, 32'h0,       LD, 1, 1, 0,  1, 1, 5'd31, 32'h00400018, 1, 7, "jal");
      step(32'h24000005, 32'h118,     32'h5,        LD, 1, 1, 0,  0, 0, 5'd0, 32'h0,        1, 8, "addiu0");
      step(32'hAD2A0000, 32'h11C,     32'h20,       LD, 1, 1, 0,  0, 0, 5'd0, 32'h0,        1, 9, "sw");
      step(32'h01200008, 32'h120,     32'h0,        LD, 1, 1, 0,  0, 0, 5'd0, 32'h0,        1, 10, "jr");
      step(32'h012A0018, 32'h124,     32'h0,        LD, 1, 1, 0,  0, 0, 5'd0, 32'h0,        1, 11, "mult");
      step(ADD8,        32'h128,      32'h9,        LD, 0, 1, 0,  0, 0, 5'd0, 32'h0,        0, 11, "bubble");
      step(ADD11,       32'h12C,      32'h55,       LD, 1, 1, 0,  1, 1, 5'd11, 32'h55,      1, 12, "add11");
      for (int i = 0; i < 3; i++)
         step(32'h8C1F0000 + i, 32'h200 + i, 32'h3 + i, ~LD, 1, 0, 0, 1, 1, 5'd11, 32'h55, 1, 12, "stall");
      check("stall wb_inst", wb_inst, ADD11);
      check("stall wb_pc", wb_pc, 32'h12C);
      step(ADD8,        32'h300,      32'h1,        LD, 1, 1, 1,  0, 0, 5'd0, 32'h0,        0, 12, "flush");
      check("flush wb_inst", wb_inst, 32'd0);

      step(ADD8,        32'h304,      32'h77,       LD, 1, 1, 0,  1, 1, 5'd8, 32'h77,       1, 13, "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      check("async rf_we", {31'd0, rf_we}, 32'd0);
      check("async count", retire_count, 32'd0);
      check("async count4", {28'd0, retire_count4}, 32'd0);
      @(negedge clk);
      wb_en = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++)
         step(ADD8, 32'h400 + 4 * i, 32'h10 + i, LD, 1, 1, 0, 1, 1, 5'd8, 32'h10 + i, 1, i + 1, "cap");
      check("wrap count4", {28'd0, retire_count4}, 32'd1);
      check("sb drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
